// File: rtl/hyper_page_bound_splitter.sv
// Cuts each 1D hyperbus transfer into chunks that never cross a HyperRAM/Flash page
// boundary; register-space and unbounded transfers pass through as a single chunk.
module hyper_page_bound_splitter #(
  parameter int L2_AWIDTH_NOAL = 12,
  parameter int TRANS_SIZE     = 16,
  parameter int ID_WIDTH       = 1
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      src_valid_i,
  output logic                      src_ready_o,
  input  logic [31:0]               src_hyper_addr_i,
  input  logic [L2_AWIDTH_NOAL-1:0] src_l2_addr_i,
  input  logic [TRANS_SIZE-1:0]     src_size_i,
  input  logic [2:0]                src_page_bound_i,
  input  logic                      src_rw_i,
  input  logic                      src_addr_space_i,
  input  logic [1:0]                src_mem_sel_i,
  input  logic [ID_WIDTH-1:0]       src_trans_id_i,
  output logic                      dst_valid_o,
  input  logic                      dst_ready_i,
  output logic [31:0]               dst_hyper_addr_o,
  output logic [L2_AWIDTH_NOAL-1:0] dst_l2_addr_o,
  output logic [TRANS_SIZE-1:0]     dst_size_o,
  output logic                      dst_rw_o,
  output logic                      dst_addr_space_o,
  output logic [1:0]                dst_mem_sel_o,
  output logic [ID_WIDTH-1:0]       dst_trans_id_o,
  output logic                      dst_last_o
);

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_SPLIT = 1'b1;

  logic                      state_q;
  logic [31:0]               addr_q;
  logic [L2_AWIDTH_NOAL-1:0] l2_q;
  logic [TRANS_SIZE-1:0]     rem_q;
  logic [2:0]                bound_q;
  logic                      rw_q;
  logic                      as_q;
  logic [1:0]                mem_q;
  logic [ID_WIDTH-1:0]       id_q;

  logic [10:0]               page;
  logic [10:0]               off;
  logic [10:0]               room;
  logic [TRANS_SIZE-1:0]     room_ext;
  logic [TRANS_SIZE-1:0]     chunk;
  logic                      last;

  // Page is at most 1 KB, so 11 bits hold both the page size and the room left in it.
  always_comb begin
    page     = 11'd128 << bound_q[1:0];
    off      = addr_q[10:0] & (page - 11'd1);
    room     = page - off;
    room_ext = TRANS_SIZE'(room);
    chunk    = ((bound_q[2] | as_q) || (rem_q <= room_ext)) ? rem_q : room_ext;
    last     = (chunk == rem_q);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      l2_q    <= '0;
      rem_q   <= '0;
      bound_q <= '0;
      rw_q    <= 1'b0;
      as_q    <= 1'b0;
      mem_q   <= '0;
      id_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // Zero-size transfers are consumed without producing a chunk.
          if (src_valid_i && (src_size_i != '0)) begin
            state_q <= ST_SPLIT;
            addr_q  <= src_hyper_addr_i;
            l2_q    <= src_l2_addr_i;
            rem_q   <= src_size_i;
            bound_q <= src_page_bound_i;
            rw_q    <= src_rw_i;
            as_q    <= src_addr_space_i;
            mem_q   <= src_mem_sel_i;
            id_q    <= src_trans_id_i;
          end
        end
        default: begin
          if (dst_ready_i) begin
            if (last) begin
              state_q <= ST_IDLE;
            end else begin
              addr_q <= addr_q + 32'(chunk);
              l2_q   <= l2_q + L2_AWIDTH_NOAL'(chunk);
              rem_q  <= rem_q - chunk;
            end
          end
        end
      endcase
    end
  end

  assign src_ready_o      = (state_q == ST_IDLE);
  assign dst_valid_o      = (state_q == ST_SPLIT);
  assign dst_last_o       = (state_q == ST_SPLIT) & last;
  assign dst_hyper_addr_o = addr_q;
  assign dst_l2_addr_o    = l2_q;
  assign dst_size_o       = chunk;
  assign dst_rw_o         = rw_q;
  assign dst_addr_space_o = as_q;
  assign dst_mem_sel_o    = mem_q;
  assign dst_trans_id_o   = id_q;

endmodule

// File: tb/tb_hyper_page_bound_splitter.sv
// Bench for hyper_page_bound_splitter: directed vector table, hand-written stall/reset
// sequence, and random transfers checked against an arithmetic chunking model.
module tb_hyper_page_bound_splitter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        src_valid_i;
  logic        src_ready_o;
  logic [31:0] src_hyper_addr_i;
  logic [11:0] src_l2_addr_i;
  logic [15:0] src_size_i;
  logic [2:0]  src_page_bound_i;
  logic        src_rw_i;
  logic        src_addr_space_i;
  logic [1:0]  src_mem_sel_i;
  logic [0:0]  src_trans_id_i;
  logic        dst_valid_o;
  logic        dst_ready_i;
  logic [31:0] dst_hyper_addr_o;
  logic [11:0] dst_l2_addr_o;
  logic [15:0] dst_size_o;
  logic        dst_rw_o;
  logic        dst_addr_space_o;
  logic [1:0]  dst_mem_sel_o;
  logic [0:0]  dst_trans_id_o;
  logic        dst_last_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  hyper_page_bound_splitter #(.L2_AWIDTH_NOAL(12), .TRANS_SIZE(16), .ID_WIDTH(1)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .src_valid_i(src_valid_i), .src_ready_o(src_ready_o),
    .src_hyper_addr_i(src_hyper_addr_i), .src_l2_addr_i(src_l2_addr_i),
    .src_size_i(src_size_i), .src_page_bound_i(src_page_bound_i),
    .src_rw_i(src_rw_i), .src_addr_space_i(src_addr_space_i),
    .src_mem_sel_i(src_mem_sel_i), .src_trans_id_i(src_trans_id_i),
    .dst_valid_o(dst_valid_o), .dst_ready_i(dst_ready_i),
    .dst_hyper_addr_o(dst_hyper_addr_o), .dst_l2_addr_o(dst_l2_addr_o),
    .dst_size_o(dst_size_o), .dst_rw_o(dst_rw_o),
    .dst_addr_space_o(dst_addr_space_o), .dst_mem_sel_o(dst_mem_sel_o),
    .dst_trans_id_o(dst_trans_id_o), .dst_last_o(dst_last_o)
  );

  typedef struct {
    logic [31:0] addr;
    logic [11:0] l2;
    logic [15:0] size;
    logic [2:0]  bound;
    logic        asp;
    int          exp_n;
    logic [15:0] exp_first;
  } vec_t;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] dst_bus();
    return {61'd0, dst_valid_o, dst_hyper_addr_o, dst_l2_addr_o, dst_size_o, dst_last_o,
            dst_rw_o, dst_addr_space_o, dst_mem_sel_o, dst_trans_id_o};
  endfunction

  // Offers one transfer, drains its chunks with random back-pressure and checks every
  // presented chunk against the page-chunking model.
  task automatic xfer(input logic [31:0] a, input logic [11:0] l, input logic [15:0] s,
                      input logic [2:0] b, input logic r, input logic asp,
                      input logic [1:0] m, input logic id, input int rdy_pct,
                      output int n_obs, output logic [15:0] first_obs);
    logic [31:0] ea[$];
    logic [11:0] el[$];
    int unsigned es[$];
    logic [31:0] cur;
    logic [11:0] cl;
    int unsigned rem, c, pg, room;
    logic [127:0] exp_bus;
    logic done, lst;
    int cyc;
    cur = a; cl = l; rem = s;
    while (rem > 0) begin
      if (b >= 3'd4 || asp) c = rem;
      else begin
        pg   = 128 << b;
        room = pg - (cur % pg);
        c    = (rem < room) ? rem : room;
      end
      ea.push_back(cur); el.push_back(cl); es.push_back(c);
      cur = cur + c; cl = cl + 12'(c); rem = rem - c;
    end
    n_obs = 0; first_obs = '0;
    @(negedge clk_i);
    chk("src_ready_idle", {127'd0, src_ready_o}, 128'd1);
    src_hyper_addr_i = a; src_l2_addr_i = l; src_size_i = s; src_page_bound_i = b;
    src_rw_i = r; src_addr_space_i = asp; src_mem_sel_i = m; src_trans_id_i = id;
    src_valid_i = 1'b1;
    @(posedge clk_i); #1;
    src_valid_i = 1'b0;
    done = (s == 16'd0); cyc = 0;
    while (!done && cyc < 4000) begin
      @(negedge clk_i);
      cyc++;
      if (n_obs < es.size())
        exp_bus = {61'd0, 1'b1, ea[n_obs], el[n_obs], 16'(es[n_obs]),
                   (n_obs == es.size() - 1), r, asp, m, id};
      else
        exp_bus = '0;
      chk("chunk", dst_bus(), exp_bus);
      chk("src_ready_busy", {127'd0, src_ready_o}, 128'd0);
      if (n_obs == 0) first_obs = dst_size_o;
      lst = dst_last_o;
      dst_ready_i = ($urandom_range(99) < rdy_pct);
      @(posedge clk_i);
      if (dst_ready_i && dst_valid_o) begin
        n_obs++;
        if (lst || n_obs > es.size()) done = 1'b1;
      end
    end
    if (!done) chk("drain_timeout", 128'd0, 128'd1);
    #1 dst_ready_i = 1'b0;
    @(negedge clk_i);
    chk("idle_after", {126'd0, dst_valid_o, src_ready_o}, 128'd1);
    chk("chunk_count", 128'(n_obs), 128'(es.size()));
  endtask

  vec_t vt[9];

  initial begin
    int n;
    logic [15:0] f;
    vt[0] = '{32'h70,       12'h010, 16'h0040, 3'd0, 1'b0, 2,  16'd16};
    vt[1] = '{32'h100,      12'h000, 16'h0300, 3'd1, 1'b0, 3,  16'd256};
    vt[2] = '{32'h7F,       12'h123, 16'h1000, 3'd5, 1'b0, 1,  16'h1000};
    vt[3] = '{32'h7F,       12'h123, 16'h1000, 3'd0, 1'b1, 1,  16'h1000};
    vt[4] = '{32'h3F0,      12'h000, 16'h0010, 3'd3, 1'b0, 1,  16'd16};
    vt[5] = '{32'hFFFFFFC0, 12'h000, 16'h0080, 3'd0, 1'b0, 2,  16'd64};
    vt[6] = '{32'h1234,     12'h000, 16'h0000, 3'd0, 1'b0, 0,  16'd0};
    vt[7] = '{32'h78,       12'hFF8, 16'h0020, 3'd0, 1'b0, 2,  16'd8};
    vt[8] = '{32'h0,        12'h000, 16'hFFFF, 3'd3, 1'b0, 64, 16'd1024};

    rst_i = 1'b1; src_valid_i = 1'b0; dst_ready_i = 1'b0;
    src_hyper_addr_i = '0; src_l2_addr_i = '0; src_size_i = '0; src_page_bound_i = '0;
    src_rw_i = 1'b0; src_addr_space_i = 1'b0; src_mem_sel_i = '0; src_trans_id_i = '0;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    chk("reset_state", {src_ready_o, dst_bus()}, {1'b1, 128'd0});

    foreach (vt[i]) begin
      xfer(vt[i].addr, vt[i].l2, vt[i].size, vt[i].bound, 1'b1, vt[i].asp, 2'd2, 1'b1,
           100, n, f);
      chk($sformatf("vec%0d_count", i), 128'(n), 128'(vt[i].exp_n));
      chk($sformatf("vec%0d_first", i), 128'(f), 128'(vt[i].exp_first));
    end

    // Stall for five cycles on chunk 2 of 4, then reset in the middle of the transfer.
    @(negedge clk_i);
    src_hyper_addr_i = 32'h0; src_l2_addr_i = 12'h100; src_size_i = 16'h200;
    src_page_bound_i = 3'd0; src_rw_i = 1'b0; src_addr_space_i = 1'b0;
    src_mem_sel_i = 2'd1; src_trans_id_i = 1'b0; src_valid_i = 1'b1; dst_ready_i = 1'b1;
    @(posedge clk_i); #1 src_valid_i = 1'b0;
    @(posedge clk_i); #1 dst_ready_i = 1'b0;
    repeat (5) begin
      @(negedge clk_i);
      chk("stall_hold", dst_bus(),
          {61'd0, 1'b1, 32'h80, 12'h180, 16'd128, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0});
      chk("stall_src_ready", {127'd0, src_ready_o}, 128'd0);
    end
    rst_i = 1'b1; dst_ready_i = 1'b1;
    @(posedge clk_i); #1 rst_i = 1'b0; dst_ready_i = 1'b0;
    @(negedge clk_i);
    chk("midreset_state", {src_ready_o, dst_bus()}, {1'b1, 128'd0});
    xfer(32'h40, 12'h0, 16'h100, 3'd0, 1'b0, 1'b0, 2'd3, 1'b1, 100, n, f);
    chk("post_reset_count", 128'(n), 128'd3);
    xfer(32'hFFFFFFF0, 12'h0, 16'h20, 3'd7, 1'b1, 1'b0, 2'd0, 1'b0, 60, n, f);
    chk("wrap_unbounded_count", 128'(n), 128'd1);

    for (int k = 0; k < 40; k++) begin
      logic [31:0] a;
      logic [15:0] s;
      a = $urandom;
      if (k % 3 == 0) a[9:0] = 10'h3FF - 10'($urandom_range(15));
      s = (k % 10 == 0) ? 16'd0 : 16'($urandom_range(1, 3000));
      xfer(a, 12'($urandom), s, 3'($urandom), ($urandom_range(7) == 0),
           ($urandom_range(7) == 0), 2'($urandom), 1'($urandom),
           $urandom_range(30, 100), n, f);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
